bcd_xs3_word_conv: RTL and testbench

Multi-digit, bidirectional BCD <-> Excess-3 converter for packed decimal words.
- Accepts one packed word through a valid/ready handshake and converts it serially, one digit per clock, least-significant digit first.
- Presents the packed result and a per-digit error mask through a second valid/ready handshake.
- Generalises the single-digit combinational BCD-to-Excess-3 converter in width (digit count) and mode (both directions), and adds invalid-code detection and flow control.

---
 rtl/bcd_xs3_pkg.sv | 18 +
 rtl/xs3_digit_conv.sv | 23 ++
 rtl/bcd_xs3_word_conv.sv | 129 ++++++++++++
 tb/tb_bcd_xs3_word_conv.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the packed-decimal BCD <-> Excess-3 converter.
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit combinational BCD <-> Excess-3 converter with invalid-code flag.
module xs3_digit_conv
  import bcd_xs3_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] digit,
  output logic [3:0] result,
  output logic       invalid
);

  always_comb begin
    result  = 4'h0;
    invalid = 1'b0;
    if (mode == MODE_BCD2XS3) begin
      if (digit <= BCD_MAX) result = digit + XS3_OFFSET;
      else                  invalid = 1'b1;
    end else begin
      if ((digit >= XS3_MIN) && (digit <= XS3_MAX)) result = digit - XS3_OFFSET;
      else                                          invalid = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_xs3_word_conv.sv
// Serial multi-digit BCD <-> Excess-3 word converter, one digit per clock, LSD first.
// Optional BCD_XS3_PARITY_EN adds out_parity (even parity of out).
module bcd_xs3_word_conv
  import bcd_xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    err
`ifdef BCD_XS3_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  state_e                  state;
  logic [CNT_W-1:0]        cnt_p0;
  logic [4*NUM_DIGITS-1:0] word_p0;
  logic                    mode_p0;
  logic [4*NUM_DIGITS-1:0] res_p1;
  logic [NUM_DIGITS-1:0]   errm_p1;

  logic [3:0]              dig_sel;
  logic [3:0]              dig_conv;
  logic                    dig_inv;
  logic [4*NUM_DIGITS-1:0] res_nxt;
  logic [NUM_DIGITS-1:0]   errm_nxt;
  logic                    accept;
  logic                    last_wr;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign last_wr   = (state == ST_CONV) && (cnt_p0 == LAST_IDX);

  assign out      = res_p1;
  assign err_mask = errm_p1;
  assign err      = |errm_p1;

  // Digit selection and result merge, driven by the digit counter
  always_comb begin
    dig_sel  = 4'h0;
    res_nxt  = res_p1;
    errm_nxt = errm_p1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt_p0 == CNT_W'(i)) begin
        dig_sel            = word_p0[4*i +: 4];
        res_nxt[4*i +: 4]  = dig_conv;
        errm_nxt[i]        = dig_inv;
      end
    end
  end

  xs3_digit_conv u_digit (
    .mode    (mode_p0),
    .digit   (dig_sel),
    .result  (dig_conv),
    .invalid (dig_inv)
  );

  // Stage p0: input capture; data only, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0 <= in;
      mode_p0 <= mode;
    end
  end

  // Stage p1: control FSM, counter and result/error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt_p0  <= '0;
      res_p1  <= '0;
      errm_p1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            res_p1  <= '0;
            errm_p1 <= '0;
            cnt_p0  <= '0;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          res_p1  <= res_nxt;
          errm_p1 <= errm_nxt;
          if (last_wr) begin
            cnt_p0 <= '0;
            state  <= ST_DONE;
          end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BCD_XS3_PARITY_EN
  // Parity tracks the final merged word so it is ready together with out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= 1'b0;
    end else if (last_wr) begin
      out_parity <= ^res_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_xs3_word_conv.sv
// Directed self-checking bench for bcd_xs3_word_conv (4-digit and 1-digit instances).
module tb_bcd_xs3_word_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, mode, out_valid, out_ready, err;
  logic [15:0] in, out;
  logic [3:0]  err_mask;
  logic        in1_valid, in1_ready, mode1, out1_valid, out1_ready, err1;
  logic [3:0]  in1, out1;
  logic [0:0]  err1_mask;
`ifdef BCD_XS3_PARITY_EN
  logic        out_parity, out1_parity;
`endif

  int n_chk = 0;
  int n_err = 0;

  bcd_xs3_word_conv #(.NUM_DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err_mask  (err_mask),
    .err       (err)
`ifdef BCD_XS3_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  bcd_xs3_word_conv #(.NUM_DIGITS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .in        (in1),
    .mode      (mode1),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out       (out1),
    .err_mask  (err1_mask),
    .err       (err1)
`ifdef BCD_XS3_PARITY_EN
    ,
    .out_parity(out1_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Accept one word on the 4-digit instance; lat counts edges from accept (inclusive) to out_valid.
  task automatic run_word(input logic [15:0] w, input logic m, output int lat);
    int g;
    in = w; mode = m; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in = 16'hFFFF; mode = ~m;
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("done_wait", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run1(input logic [3:0] w, input logic m, output int lat);
    in1 = w; mode1 = m; in1_valid = 1'b1;
    check("n1_ready", {31'd0, in1_ready}, 32'd1);
    @(posedge clk); #1;
    in1_valid = 1'b0; in1 = 4'hF;
    lat = 1;
    while (!out1_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("n1_done_wait", {31'd0, out1_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in = '0; mode = 1'b0; out_ready = 1'b1;
    in1_valid = 1'b0; in1 = '0; mode1 = 1'b0; out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out",       {16'd0, out},       32'h0);
    check("rst_err_mask",  {28'd0, err_mask},  32'h0);
    check("rst_err",       {31'd0, err},       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic conversions
    run_word(16'h1234, 1'b0, lat);
    check("t1_lat",  lat, 32'd5);
    check("t1_out",  {16'd0, out}, 32'h4567);
    check("t1_mask", {28'd0, err_mask}, 32'h0);
    check("t1_err",  {31'd0, err}, 32'd0);
`ifdef BCD_XS3_PARITY_EN
    check("t1_par",  {31'd0, out_parity}, 32'd0);
`endif
    @(posedge clk); #1;
    check("t1_vld_1cyc", {31'd0, out_valid}, 32'd0);

    run_word(16'h9A05, 1'b0, lat);
    check("t2_out",  {16'd0, out}, 32'hC038);
    check("t2_mask", {28'd0, err_mask}, 32'h4);
    check("t2_err",  {31'd0, err}, 32'd1);
`ifdef BCD_XS3_PARITY_EN
    check("t2_par",  {31'd0, out_parity}, 32'd1);
`endif
    @(posedge clk); #1;

    run_word(16'h4567, 1'b1, lat);
    check("t3_out",  {16'd0, out}, 32'h1234);
    check("t3_mask", {28'd0, err_mask}, 32'h0);
    @(posedge clk); #1;

    run_word(16'h3D2C, 1'b1, lat);
    check("t4_out",  {16'd0, out}, 32'h0009);
    check("t4_mask", {28'd0, err_mask}, 32'h6);
    check("t4_err",  {31'd0, err}, 32'd1);
    @(posedge clk); #1;

    run_word(16'h9999, 1'b0, lat);
    check("t5_out",  {16'd0, out}, 32'hCCCC);
    check("t5_mask", {28'd0, err_mask}, 32'h0);
    @(posedge clk); #1;

    run_word(16'h0F12, 1'b1, lat);
    check("t6_out",  {16'd0, out}, 32'h0000);
    check("t6_mask", {28'd0, err_mask}, 32'hF);
    check("t6_err",  {31'd0, err}, 32'd1);
    @(posedge clk); #1;

    // Backpressure with a competing word held on the input
    out_ready = 1'b0;
    run_word(16'h1234, 1'b0, lat);
    in = 16'h4567; mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_vld",   {31'd0, out_valid}, 32'd1);
      check("bp_out",   {16'd0, out}, 32'h4567);
      check("bp_mask",  {28'd0, err_mask}, 32'h0);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_vld",   {31'd0, out_valid}, 32'd0);
    check("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("bp_accepted",  {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; in = 16'hFFFF;
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp2_lat", lat, 32'd5);
    check("bp2_out", {16'd0, out}, 32'h1234);
    @(posedge clk); #1;

    // Reset during conversion
    in = 16'h1234; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mr_ready", {31'd0, in_ready}, 32'd1);
    check("mr_vld",   {31'd0, out_valid}, 32'd0);
    check("mr_out",   {16'd0, out}, 32'h0);
    check("mr_mask",  {28'd0, err_mask}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_no_out", {31'd0, out_valid}, 32'd0);
    run_word(16'h0000, 1'b0, lat);
    check("mr2_lat", lat, 32'd5);
    check("mr2_out", {16'd0, out}, 32'h3333);
    @(posedge clk); #1;

    // Single-digit instance
    run1(4'h9, 1'b0, lat);
    check("n1_lat",  lat, 32'd2);
    check("n1_out",  {28'd0, out1}, 32'hC);
    check("n1_err",  {31'd0, err1}, 32'd0);
`ifdef BCD_XS3_PARITY_EN
    check("n1_par",  {31'd0, out1_parity}, 32'd0);
`endif
    @(posedge clk); #1;
    run1(4'hA, 1'b0, lat);
    check("n1b_out",  {28'd0, out1}, 32'h0);
    check("n1b_mask", {31'd0, err1_mask}, 32'd1);
    check("n1b_err",  {31'd0, err1}, 32'd1);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
